// File: rtl/button_debounce_select.sv
// -----------------------------------------------------------------------------
// button_debounce_select
//
// Qualifies a raw push-button against the divided debounce tick and produces
// clean one-cycle press / release / long-press strobes, a debounced level, and
// the mode-selection counter advanced by qualified presses. Nothing downstream
// should ever see a raw button edge.
//
// Parameters:
//   ACTIVE_LOW    1 = button_in low means pressed, 0 = high means pressed
//   STABLE_TICKS  consecutive agreeing tick samples to accept a change (2..31)
//   LONG_TICKS    held tick samples after qualification for long press (1..65535)
//   NUM_STATES    modulus of the mode counter (2..8)
//
// Ports:
//   clk               system clock
//   rst_n             asynchronous active-low reset
//   button_in         raw asynchronous button pin
//   debounce_tick     divider square wave, same clock domain; rising edge = sample
//   button_level      debounced pressed level
//   press_pulse       one-clk strobe when a press is qualified
//   release_pulse     one-clk strobe when a release is qualified
//   long_press_pulse  one-clk strobe, at most once per press
//   state             mode counter, 0..NUM_STATES-1
// -----------------------------------------------------------------------------
module button_debounce_select #(
    parameter int unsigned ACTIVE_LOW   = 1,
    parameter int unsigned STABLE_TICKS = 4,
    parameter int unsigned LONG_TICKS   = 10000,
    parameter int unsigned NUM_STATES   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       button_in,
    input  logic       debounce_tick,
    output logic       button_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_press_pulse,
    output logic [2:0] state
);

    // Pin level that corresponds to "not pressed"; the synchronizer resets here
    // so reset release never looks like a press edge.
    localparam logic        RELEASED_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [5:0]  STABLE_C     = 6'(STABLE_TICKS);
    localparam logic [16:0] LONG_C       = 17'(LONG_TICKS);
    localparam logic [2:0]  LAST_STATE   = 3'(NUM_STATES - 1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } fsm_t;

    logic        sync1_r;
    logic        sync2_r;
    logic        tick_d_r;
    fsm_t        fsm_r;
    logic [4:0]  cnt_r;
    logic [15:0] hold_r;

    logic        pressed_s;
    logic        tick_en_s;
    logic [5:0]  cnt_inc_s;
    logic [16:0] hold_inc_s;
    logic [2:0]  state_next_s;

    // Two-flop synchronizer on the raw pin, parked at the released level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= RELEASED_LVL;
            sync2_r <= RELEASED_LVL;
        end else begin
            sync1_r <= button_in;
            sync2_r <= sync1_r;
        end
    end

    // Delayed tick; reset high so a tick already high at reset release is not
    // taken as a fresh sample point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_d_r <= 1'b1;
        end else begin
            tick_d_r <= debounce_tick;
        end
    end

    // Sample-point detect, pressed decode, widened increments and the wrap of
    // the mode counter (out-of-range values also land on 0).
    always_comb begin
        tick_en_s    = debounce_tick & ~tick_d_r;
        pressed_s    = sync2_r ^ RELEASED_LVL;
        cnt_inc_s    = {1'b0, cnt_r} + 6'd1;
        hold_inc_s   = {1'b0, hold_r} + 17'd1;
        if (state >= LAST_STATE) begin
            state_next_s = 3'd0;
        end else begin
            state_next_s = state + 3'd1;
        end
    end

    // Qualification FSM with its counters, registered strobes, level and mode
    // counter. Everything except the strobe clearing advances only on tick_en_s.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_r            <= IDLE;
            cnt_r            <= 5'd0;
            hold_r           <= 16'd0;
            button_level     <= 1'b0;
            press_pulse      <= 1'b0;
            release_pulse    <= 1'b0;
            long_press_pulse <= 1'b0;
            state            <= 3'd0;
        end else begin
            press_pulse      <= 1'b0;
            release_pulse    <= 1'b0;
            long_press_pulse <= 1'b0;
            if (tick_en_s) begin
                case (fsm_r)
                    IDLE: begin
                        if (pressed_s) begin
                            fsm_r <= PRESS_CHK;
                            cnt_r <= 5'd1;
                        end else begin
                            cnt_r <= 5'd0;
                        end
                    end
                    PRESS_CHK: begin
                        if (pressed_s) begin
                            if (cnt_inc_s == STABLE_C) begin
                                fsm_r        <= HELD;
                                cnt_r        <= 5'd0;
                                hold_r       <= 16'd0;
                                button_level <= 1'b1;
                                press_pulse  <= 1'b1;
                                state        <= state_next_s;
                            end else begin
                                cnt_r <= cnt_inc_s[4:0];
                            end
                        end else begin
                            fsm_r <= IDLE;
                            cnt_r <= 5'd0;
                        end
                    end
                    HELD: begin
                        if (!pressed_s) begin
                            fsm_r <= RELEASE_CHK;
                            cnt_r <= 5'd1;
                        end else if (hold_inc_s <= LONG_C) begin
                            // Saturates at LONG_C, so the strobe fires once.
                            hold_r <= hold_inc_s[15:0];
                            if (hold_inc_s == LONG_C) begin
                                long_press_pulse <= 1'b1;
                                state            <= 3'd0;
                            end else begin
                                long_press_pulse <= 1'b0;
                            end
                        end else begin
                            hold_r <= hold_r;
                        end
                    end
                    RELEASE_CHK: begin
                        if (!pressed_s) begin
                            if (cnt_inc_s == STABLE_C) begin
                                fsm_r         <= IDLE;
                                cnt_r         <= 5'd0;
                                button_level  <= 1'b0;
                                release_pulse <= 1'b1;
                            end else begin
                                cnt_r <= cnt_inc_s[4:0];
                            end
                        end else begin
                            // Short release glitch: back to HELD, hold_r kept so
                            // long-press timing is not restarted.
                            fsm_r <= HELD;
                            cnt_r <= 5'd0;
                        end
                    end
                    default: begin
                        fsm_r        <= IDLE;
                        cnt_r        <= 5'd0;
                        hold_r       <= 16'd0;
                        button_level <= 1'b0;
                    end
                endcase
            end else begin
                fsm_r <= fsm_r;
            end
        end
    end

endmodule

// File: tb/tb_button_debounce_select.sv
module tb_button_debounce_select;

    localparam int ST = 4;
    localparam int LT = 10;
    localparam int NS = 5;
    localparam int TP = 256;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       button_in;
    logic       debounce_tick;
    logic       button_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_press_pulse;
    logic [2:0] state;

    button_debounce_select #(
        .ACTIVE_LOW   (1),
        .STABLE_TICKS (ST),
        .LONG_TICKS   (LT),
        .NUM_STATES   (NS)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .button_in        (button_in),
        .debounce_tick    (debounce_tick),
        .button_level     (button_level),
        .press_pulse      (press_pulse),
        .release_pulse    (release_pulse),
        .long_press_pulse (long_press_pulse),
        .state            (state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_press = 0;
    int n_rel   = 0;
    int n_long  = 0;
    int tick_cnt = 0;

    // Reference model: history of pin values, last tick level, and the
    // run-length view of debouncing (a change is accepted once ST consecutive
    // samples disagree with the accepted level).
    logic bhist0, bhist1;
    logic m_tprev;
    int   m_lvl, m_run, m_prevp, m_hold, m_state;
    logic e_press, e_rel, e_long;
    logic [6:0] exp_v;
    wire  [6:0] obs_v = {button_level, press_pulse, release_pulse, long_press_pulse, state};

    logic seg_b[$];
    int   seg_n[$];

    task automatic model_reset();
        bhist0 = 1'b1; bhist1 = 1'b1; m_tprev = 1'b1;
        m_lvl = 0; m_run = 0; m_prevp = 0; m_hold = 0; m_state = 0;
        e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
        exp_v = 7'd0;
    endtask

    task automatic model_sample(input bit p);
        if (m_lvl == 0) begin
            m_run = p ? m_run + 1 : 0;
            if (m_run == ST) begin
                m_lvl = 1; m_run = 0; m_hold = 0; m_prevp = 1;
                e_press = 1'b1;
                m_state = (m_state + 1) % NS;
            end
        end else begin
            m_run = p ? 0 : m_run + 1;
            if (m_run == ST) begin
                m_lvl = 0; m_run = 0;
                e_rel = 1'b1;
            end else if (p && m_prevp == 1 && m_hold < LT) begin
                m_hold = m_hold + 1;
                if (m_hold == LT) begin
                    e_long = 1'b1;
                    m_state = 0;
                end
            end
            m_prevp = p ? 1 : 0;
        end
    endtask

    // One clock: drive at the falling edge, advance the model through the
    // next rising edge, then observe #1 later and return at the next falling edge.
    task automatic cyc(input logic b);
        button_in     = b;
        debounce_tick = (tick_cnt >= TP / 2);
        tick_cnt      = (tick_cnt + 1) % TP;
        e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
        if (debounce_tick && !m_tprev) model_sample(bhist1 == 1'b0);
        bhist1  = bhist0;
        bhist0  = button_in;
        m_tprev = debounce_tick;
        exp_v   = {m_lvl[0], e_press, e_rel, e_long, 3'(m_state)};
        @(posedge clk);
        #1;
        if (press_pulse)      n_press++;
        if (release_pulse)    n_rel++;
        if (long_press_pulse) n_long++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; button_in = 1'b1; debounce_tick = 1'b0;
        model_reset();
        #1;
        total++;
        if (obs_v !== 7'd0) begin bad++; $display("FAIL reset_value: got %b want %b", obs_v, 7'd0); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10 * TP; c++) begin
            cyc(1'b1);
            total++;
            if (obs_v !== exp_v) begin bad++; $display("FAIL reset_idle c=%0d: got %b want %b", c, obs_v, exp_v); end
        end
        total++;
        if (n_press + n_rel + n_long !== 0) begin bad++; $display("FAIL reset_strobes: got %0d want 0", n_press + n_rel + n_long); end
    endtask

    task automatic test_clean_press();
        int p0 = n_press, r0 = n_rel;
        seg_b.delete(); seg_n.delete();
        seg_b.push_back(1'b1); seg_n.push_back($urandom_range(1, TP));
        seg_b.push_back(1'b0); seg_n.push_back(8 * TP);
        seg_b.push_back(1'b1); seg_n.push_back(8 * TP);
        for (int s = 0; s < seg_b.size(); s++) begin
            for (int c = 0; c < seg_n[s]; c++) begin
                cyc(seg_b[s]);
                total++;
                if (obs_v !== exp_v) begin bad++; $display("FAIL clean_press s=%0d c=%0d: got %b want %b", s, c, obs_v, exp_v); end
            end
            if (s == 1) begin
                total++;
                if (button_level !== 1'b1 || state !== 3'd1) begin bad++; $display("FAIL clean_held: got lvl=%b st=%0d want lvl=1 st=1", button_level, state); end
            end
        end
        total++;
        if (n_press - p0 !== 1 || n_rel - r0 !== 1) begin bad++; $display("FAIL clean_counts: got press=%0d rel=%0d want 1 1", n_press - p0, n_rel - r0); end
        total++;
        if (button_level !== 1'b0) begin bad++; $display("FAIL clean_level: got %b want 0", button_level); end
    endtask

    task automatic test_bounce();
        int p0 = n_press, r0 = n_rel, acc = 0;
        logic b = 1'b0;
        seg_b.delete(); seg_n.delete();
        while (acc < 3 * TP) begin
            int d = $urandom_range(40, 60);
            seg_b.push_back(b); seg_n.push_back(d);
            acc += d; b = ~b;
        end
        seg_b.push_back(1'b0); seg_n.push_back(6 * TP);
        seg_b.push_back(1'b1); seg_n.push_back(6 * TP);
        for (int s = 0; s < seg_b.size(); s++) begin
            for (int c = 0; c < seg_n[s]; c++) begin
                cyc(seg_b[s]);
                total++;
                if (obs_v !== exp_v) begin bad++; $display("FAIL bounce s=%0d c=%0d: got %b want %b", s, c, obs_v, exp_v); end
            end
        end
        total++;
        if (n_press - p0 !== 1 || n_rel - r0 !== 1) begin bad++; $display("FAIL bounce_counts: got press=%0d rel=%0d want 1 1", n_press - p0, n_rel - r0); end
        total++;
        if (state !== 3'd2) begin bad++; $display("FAIL bounce_state: got %0d want 2", state); end
    endtask

    task automatic test_glitch();
        int r0 = n_rel;
        int g = $urandom_range(1, ST - 1);
        seg_b.delete(); seg_n.delete();
        seg_b.push_back(1'b1); seg_n.push_back($urandom_range(1, TP));
        seg_b.push_back(1'b0); seg_n.push_back(6 * TP);
        seg_b.push_back(1'b1); seg_n.push_back(g * TP);
        seg_b.push_back(1'b0); seg_n.push_back(3 * TP);
        seg_b.push_back(1'b1); seg_n.push_back(6 * TP);
        for (int s = 0; s < seg_b.size(); s++) begin
            for (int c = 0; c < seg_n[s]; c++) begin
                cyc(seg_b[s]);
                total++;
                if (obs_v !== exp_v) begin bad++; $display("FAIL glitch s=%0d c=%0d: got %b want %b", s, c, obs_v, exp_v); end
            end
            if (s == 3) begin
                total++;
                if (n_rel - r0 !== 0 || button_level !== 1'b1 || state !== 3'd3) begin
                    bad++; $display("FAIL glitch_hold: got rel=%0d lvl=%b st=%0d want 0 1 3", n_rel - r0, button_level, state);
                end
            end
        end
        total++;
        if (n_rel - r0 !== 1) begin bad++; $display("FAIL glitch_release: got %0d want 1", n_rel - r0); end
    endtask

    task automatic test_long_press();
        int p0 = n_press, l0 = n_long;
        seg_b.delete(); seg_n.delete();
        seg_b.push_back(1'b1); seg_n.push_back($urandom_range(1, TP));
        seg_b.push_back(1'b0); seg_n.push_back(30 * TP);
        seg_b.push_back(1'b1); seg_n.push_back(6 * TP);
        for (int s = 0; s < seg_b.size(); s++) begin
            for (int c = 0; c < seg_n[s]; c++) begin
                cyc(seg_b[s]);
                total++;
                if (obs_v !== exp_v) begin bad++; $display("FAIL long_press s=%0d c=%0d: got %b want %b", s, c, obs_v, exp_v); end
            end
        end
        total++;
        if (n_press - p0 !== 1 || n_long - l0 !== 1) begin bad++; $display("FAIL long_counts: got press=%0d long=%0d want 1 1", n_press - p0, n_long - l0); end
        total++;
        if (state !== 3'd0) begin bad++; $display("FAIL long_state: got %0d want 0", state); end
    endtask

    task automatic test_five_presses();
        int p0 = n_press;
        int exp_seq[5] = '{1, 2, 3, 4, 0};
        seg_b.delete(); seg_n.delete();
        for (int k = 0; k < 5; k++) begin
            seg_b.push_back(1'b0); seg_n.push_back(5 * TP);
            seg_b.push_back(1'b1); seg_n.push_back(5 * TP);
        end
        for (int s = 0; s < seg_b.size(); s++) begin
            for (int c = 0; c < seg_n[s]; c++) begin
                cyc(seg_b[s]);
                total++;
                if (obs_v !== exp_v) begin bad++; $display("FAIL five s=%0d c=%0d: got %b want %b", s, c, obs_v, exp_v); end
            end
            if (s % 2 == 1) begin
                total++;
                if (state !== 3'(exp_seq[s / 2])) begin bad++; $display("FAIL five_state k=%0d: got %0d want %0d", s / 2, state, exp_seq[s / 2]); end
            end
        end
        total++;
        if (n_press - p0 !== 5) begin bad++; $display("FAIL five_count: got %0d want 5", n_press - p0); end
    endtask

    task automatic test_reset_mid_hold();
        int p0;
        for (int c = 0; c < 8 * TP; c++) begin
            cyc(1'b0);
            total++;
            if (obs_v !== exp_v) begin bad++; $display("FAIL midrst_pre c=%0d: got %b want %b", c, obs_v, exp_v); end
        end
        total++;
        if (button_level !== 1'b1 || state !== 3'd1) begin bad++; $display("FAIL midrst_held: got lvl=%b st=%0d want 1 1", button_level, state); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (obs_v !== 7'd0) begin bad++; $display("FAIL midrst_async: got %b want %b", obs_v, 7'd0); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        p0 = n_press;
        seg_b.delete(); seg_n.delete();
        seg_b.push_back(1'b0); seg_n.push_back(6 * TP);
        seg_b.push_back(1'b1); seg_n.push_back(6 * TP);
        for (int s = 0; s < seg_b.size(); s++) begin
            for (int c = 0; c < seg_n[s]; c++) begin
                cyc(seg_b[s]);
                total++;
                if (obs_v !== exp_v) begin bad++; $display("FAIL midrst_post s=%0d c=%0d: got %b want %b", s, c, obs_v, exp_v); end
            end
        end
        total++;
        if (n_press - p0 !== 1 || state !== 3'd1) begin bad++; $display("FAIL midrst_requal: got press=%0d st=%0d want 1 1", n_press - p0, state); end
    endtask

    task automatic test_random();
        for (int s = 0; s < 24; s++) begin
            logic b = 1'($urandom_range(0, 1));
            int   n = $urandom_range(1, 3 * TP);
            for (int c = 0; c < n; c++) begin
                cyc(b);
                total++;
                if (obs_v !== exp_v) begin bad++; $display("FAIL random s=%0d c=%0d: got %b want %b", s, c, obs_v, exp_v); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_long_press();
        test_five_presses();
        test_reset_mid_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
